// File: rtl/cpu_axi_master_bridge.sv
// cpu_axi_master_bridge
// Converts a CPU request/wait memory port into single-beat AXI4 master
// transactions. Reads use AR/R, writes use AW/W/B. The CPU is stalled through
// cpu_wait_o until the response arrives, then released for exactly one cycle
// (DONE), during which cpu_dout_o carries the read data.
module cpu_axi_master_bridge #(
    parameter int unsigned     ID_W      = 4,
    parameter logic [ID_W-1:0] MASTER_ID = '0
) (
    input  logic            clk,
    input  logic            rst,

    // CPU side
    input  logic            cpu_request_i,
    input  logic [3:0]      cpu_bweb_i,
    input  logic [31:0]     cpu_addr_i,
    input  logic [31:0]     cpu_din_i,
    output logic            cpu_wait_o,
    output logic [31:0]     cpu_dout_o,
    output logic            bus_err_o,

    // AXI read address channel
    output logic [ID_W-1:0] ARID,
    output logic [31:0]     ARADDR,
    output logic [3:0]      ARLEN,
    output logic [2:0]      ARSIZE,
    output logic [1:0]      ARBURST,
    output logic            ARVALID,
    input  logic            ARREADY,

    // AXI read data channel
    input  logic [ID_W-1:0] RID,
    input  logic [31:0]     RDATA,
    input  logic [1:0]      RRESP,
    input  logic            RLAST,
    input  logic            RVALID,
    output logic            RREADY,

    // AXI write address channel
    output logic [ID_W-1:0] AWID,
    output logic [31:0]     AWADDR,
    output logic [3:0]      AWLEN,
    output logic [2:0]      AWSIZE,
    output logic [1:0]      AWBURST,
    output logic            AWVALID,
    input  logic            AWREADY,

    // AXI write data channel
    output logic [31:0]     WDATA,
    output logic [3:0]      WSTRB,
    output logic            WLAST,
    output logic            WVALID,
    input  logic            WREADY,

    // AXI write response channel
    input  logic [ID_W-1:0] BID,
    input  logic [1:0]      BRESP,
    input  logic            BVALID,
    output logic            BREADY
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_RESP = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    // Request captured in IDLE; held stable for the whole transaction so the
    // AXI payloads never change while VALID is high.
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;

    // AW and W complete independently; these remember which one is finished.
    logic        r_aw_done;
    logic        r_w_done;

    logic [31:0] r_dout;
    logic        r_bus_err;

    logic        w_capture;
    logic        w_is_read;
    logic        w_ar_hs;
    logic        w_r_hs;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_b_hs;
    logic        w_aw_fin;
    logic        w_w_fin;
    logic        w_r_err;
    logic        w_b_err;

    // A response is bad if it is not OKAY or carries someone else's ID.
    function automatic logic resp_bad(input logic [1:0] resp, input logic [ID_W-1:0] id);
        return (resp != 2'b00) || (id != MASTER_ID);
    endfunction

    assign w_capture = (r_state == S_IDLE) && cpu_request_i;
    assign w_is_read = &cpu_bweb_i;

    assign w_ar_hs   = ARVALID && ARREADY;
    assign w_r_hs    = RVALID  && RREADY;
    assign w_aw_hs   = AWVALID && AWREADY;
    assign w_w_hs    = WVALID  && WREADY;
    assign w_b_hs    = BVALID  && BREADY;

    // Either already done in an earlier cycle, or completing right now.
    assign w_aw_fin  = r_aw_done || w_aw_hs;
    assign w_w_fin   = r_w_done  || w_w_hs;

    // Single-beat reads must also be flagged as the last beat.
    assign w_r_err   = resp_bad(RRESP, RID) || !RLAST;
    assign w_b_err   = resp_bad(BRESP, BID);

    // Fixed single-beat, 32-bit, INCR attributes.
    assign ARID      = MASTER_ID;
    assign ARLEN     = 4'd0;
    assign ARSIZE    = 3'b010;
    assign ARBURST   = 2'b01;
    assign AWID      = MASTER_ID;
    assign AWLEN     = 4'd0;
    assign AWSIZE    = 3'b010;
    assign AWBURST   = 2'b01;
    assign WLAST     = 1'b1;

    assign ARADDR    = r_addr;
    assign AWADDR    = r_addr;
    assign WDATA     = r_wdata;
    assign WSTRB     = r_wstrb;

    assign cpu_dout_o = r_dout;
    assign bus_err_o  = r_bus_err;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; each channel advances only on its own handshake.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_capture) begin
                    w_next_state = w_is_read ? S_RD_ADDR : S_WR_REQ;
                end
            end
            S_RD_ADDR: begin
                if (w_ar_hs) begin
                    w_next_state = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (w_r_hs) begin
                    w_next_state = S_DONE;
                end
            end
            S_WR_REQ: begin
                if (w_aw_fin && w_w_fin) begin
                    w_next_state = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (w_b_hs) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Channel handshake outputs and CPU stall, decoded from the current state.
    always_comb begin
        ARVALID    = (r_state == S_RD_ADDR);
        RREADY     = (r_state == S_RD_DATA);
        AWVALID    = (r_state == S_WR_REQ) && !r_aw_done;
        WVALID     = (r_state == S_WR_REQ) && !r_w_done;
        BREADY     = (r_state == S_WR_RESP);
        // Combinational so the CPU stalls in the very cycle it raises a request.
        cpu_wait_o = cpu_request_i && (r_state != S_DONE);
    end

    // Latch the CPU address, write data and active-high strobes on acceptance.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else if (w_capture) begin
            r_addr  <= cpu_addr_i;
            r_wdata <= cpu_din_i;
            r_wstrb <= ~cpu_bweb_i;
        end
    end

    // Track AW/W completion; cleared whenever we are outside WR_REQ so both
    // channels start fresh on entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (r_state != S_WR_REQ) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                r_w_done <= 1'b1;
            end
        end
    end

    // Read data register: only a completed read updates it, writes leave it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dout <= '0;
        end else if ((r_state == S_RD_DATA) && w_r_hs) begin
            r_dout <= RDATA;
        end
    end

    // One-cycle error pulse, aligned with the DONE cycle of the transaction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= ((r_state == S_RD_DATA) && w_r_hs && w_r_err) ||
                         ((r_state == S_WR_RESP) && w_b_hs && w_b_err);
        end
    end

endmodule

// File: tb/tb_cpu_axi_master_bridge.sv
// Testbench for cpu_axi_master_bridge: table of transactions driven against a
// cycle-scheduled AXI slave, with a scoreboard queue for the completion data.
module tb_cpu_axi_master_bridge;

    localparam int        ID_W = 4;
    localparam logic [3:0] MID = 4'h5;

    logic            clk;
    logic            rst;
    logic            cpu_request_i;
    logic [3:0]      cpu_bweb_i;
    logic [31:0]     cpu_addr_i;
    logic [31:0]     cpu_din_i;
    logic            cpu_wait_o;
    logic [31:0]     cpu_dout_o;
    logic            bus_err_o;
    logic [ID_W-1:0] ARID;
    logic [31:0]     ARADDR;
    logic [3:0]      ARLEN;
    logic [2:0]      ARSIZE;
    logic [1:0]      ARBURST;
    logic            ARVALID;
    logic            ARREADY;
    logic [ID_W-1:0] RID;
    logic [31:0]     RDATA;
    logic [1:0]      RRESP;
    logic            RLAST;
    logic            RVALID;
    logic            RREADY;
    logic [ID_W-1:0] AWID;
    logic [31:0]     AWADDR;
    logic [3:0]      AWLEN;
    logic [2:0]      AWSIZE;
    logic [1:0]      AWBURST;
    logic            AWVALID;
    logic            AWREADY;
    logic [31:0]     WDATA;
    logic [3:0]      WSTRB;
    logic            WLAST;
    logic            WVALID;
    logic            WREADY;
    logic [ID_W-1:0] BID;
    logic [1:0]      BRESP;
    logic            BVALID;
    logic            BREADY;

    cpu_axi_master_bridge #(.ID_W(ID_W), .MASTER_ID(MID)) dut (
        .clk(clk), .rst(rst),
        .cpu_request_i(cpu_request_i), .cpu_bweb_i(cpu_bweb_i),
        .cpu_addr_i(cpu_addr_i), .cpu_din_i(cpu_din_i),
        .cpu_wait_o(cpu_wait_o), .cpu_dout_o(cpu_dout_o), .bus_err_o(bus_err_o),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
        .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  bweb;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        bad_id;
        logic        rlast;
        int          ar_dly;
        int          aw_dly;
        int          w_dly;
        int          rsp_dly;
        logic        hold;
        logic        drop;
        logic [3:0]  exp_strb;
        logic [31:0] exp_dout;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] dout;
        logic        err;
    } exp_t;

    vec_t  vecs[$];
    exp_t  sb_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    ar_hs_cnt = 0;
    logic [31:0] cur_dout = 32'h0;

    always @(posedge clk) begin
        if (rst && ARVALID && ARREADY) ar_hs_cnt <= ar_hs_cnt + 1;
    end

    task automatic check(input string name, input int vi, input int cyc,
                         input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s vec=%0d cyc=%0d got=%h exp=%h", name, vi, cyc, got, exp);
        end
    endtask

    task automatic add(input logic [3:0] bweb, input logic [31:0] addr,
                       input logic [31:0] din, input logic [31:0] rdata,
                       input logic [1:0] resp, input logic bad_id, input logic rlast,
                       input int ar_dly, input int aw_dly, input int w_dly,
                       input int rsp_dly, input logic hold, input logic drop,
                       input logic [3:0] exp_strb, input logic [31:0] exp_dout,
                       input logic exp_err);
        vec_t v;
        v.bweb = bweb; v.addr = addr; v.din = din; v.rdata = rdata;
        v.resp = resp; v.bad_id = bad_id; v.rlast = rlast;
        v.ar_dly = ar_dly; v.aw_dly = aw_dly; v.w_dly = w_dly; v.rsp_dly = rsp_dly;
        v.hold = hold; v.drop = drop;
        v.exp_strb = exp_strb; v.exp_dout = exp_dout; v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    task automatic idle_slave();
        ARREADY = 0; AWREADY = 0; WREADY = 0;
        RVALID = 0; RDATA = 32'hBAD0_0000; RRESP = 0; RID = MID; RLAST = 1;
        BVALID = 0; BRESP = 0; BID = MID;
    endtask

    task automatic check_all_idle(input string tag, input int vi);
        check({tag, "_arvalid"}, vi, 0, 32'(ARVALID), 32'd0);
        check({tag, "_rready"},  vi, 0, 32'(RREADY),  32'd0);
        check({tag, "_awvalid"}, vi, 0, 32'(AWVALID), 32'd0);
        check({tag, "_wvalid"},  vi, 0, 32'(WVALID),  32'd0);
        check({tag, "_bready"},  vi, 0, 32'(BREADY),  32'd0);
        check({tag, "_dout"},    vi, 0, cpu_dout_o,   32'd0);
        check({tag, "_buserr"},  vi, 0, 32'(bus_err_o), 32'd0);
        check({tag, "_araddr"},  vi, 0, ARADDR,       32'd0);
    endtask

    // One transaction: cycle 0 is the IDLE cycle where the request is seen;
    // the slave answers on a fixed schedule derived from the vector delays.
    task automatic do_txn(input int vi);
        vec_t v;
        exp_t e;
        exp_t got_e;
        logic rd;
        int   aw_end, w_end, a_end, rs, re, done;
        v  = vecs[vi];
        rd = (v.bweb == 4'hF);
        aw_end = 1 + v.aw_dly;
        w_end  = 1 + v.w_dly;
        if (rd) a_end = 1 + v.ar_dly;
        else    a_end = (aw_end > w_end) ? aw_end : w_end;
        rs   = a_end + 1;
        re   = rs + v.rsp_dly;
        done = re + 1;

        @(negedge clk);
        cpu_request_i = 1; cpu_bweb_i = v.bweb; cpu_addr_i = v.addr; cpu_din_i = v.din;
        idle_slave();
        e.dout = v.exp_dout; e.err = v.exp_err;
        sb_q.push_back(e);
        #1;
        check("wait_c0", vi, 0, 32'(cpu_wait_o), 32'd1);
        check("arvalid_c0", vi, 0, 32'(ARVALID), 32'd0);
        check("awvalid_c0", vi, 0, 32'(AWVALID), 32'd0);

        for (int cyc = 1; cyc <= done; cyc++) begin
            @(negedge clk);
            if (v.drop) cpu_request_i = 0;
            idle_slave();
            ARREADY = rd && (cyc == a_end);
            AWREADY = !rd && (cyc == aw_end);
            WREADY  = !rd && (cyc == w_end);
            RID   = v.bad_id ? (MID ^ 4'h1) : MID;
            BID   = v.bad_id ? (MID ^ 4'h1) : MID;
            RRESP = v.resp; BRESP = v.resp; RLAST = v.rlast;
            RDATA = 32'hBAD0_0000 | 32'(cyc);
            if (cyc == re) begin
                RVALID = rd;
                BVALID = !rd;
                if (rd) RDATA = v.rdata;
            end
            #1;
            check("arvalid", vi, cyc, 32'(ARVALID), 32'(rd && cyc <= a_end));
            check("awvalid", vi, cyc, 32'(AWVALID), 32'(!rd && cyc <= aw_end));
            check("wvalid",  vi, cyc, 32'(WVALID),  32'(!rd && cyc <= w_end));
            check("rready",  vi, cyc, 32'(RREADY),  32'(rd && cyc >= rs && cyc <= re));
            check("bready",  vi, cyc, 32'(BREADY),  32'(!rd && cyc >= rs && cyc <= re));
            check("wait",    vi, cyc, 32'(cpu_wait_o), 32'(!v.drop && cyc != done));
            if (ARVALID) begin
                check("araddr", vi, cyc, ARADDR, v.addr);
                check("ar_attr", vi, cyc, {17'd0, ARID, ARLEN, ARSIZE, ARBURST},
                      {17'd0, MID, 4'd0, 3'b010, 2'b01});
            end
            if (AWVALID) begin
                check("awaddr", vi, cyc, AWADDR, v.addr);
                check("aw_attr", vi, cyc, {17'd0, AWID, AWLEN, AWSIZE, AWBURST},
                      {17'd0, MID, 4'd0, 3'b010, 2'b01});
            end
            if (WVALID) begin
                check("wdata", vi, cyc, WDATA, v.din);
                check("wstrb", vi, cyc, 32'(WSTRB), 32'(v.exp_strb));
                check("wlast", vi, cyc, 32'(WLAST), 32'd1);
            end
            if (cyc != done) begin
                check("dout_hold", vi, cyc, cpu_dout_o, cur_dout);
                check("buserr_idle", vi, cyc, 32'(bus_err_o), 32'd0);
            end else if (sb_q.size() == 0) begin
                check("sb_empty", vi, cyc, 32'd0, 32'd1);
            end else begin
                got_e = sb_q.pop_front();
                check("dout", vi, cyc, cpu_dout_o, got_e.dout);
                check("buserr", vi, cyc, 32'(bus_err_o), 32'(got_e.err));
                cur_dout = got_e.dout;
            end
        end

        if (!v.hold) begin
            @(negedge clk);
            cpu_request_i = 0;
            idle_slave();
            #1;
            check("wait_after", vi, 0, 32'(cpu_wait_o), 32'd0);
            check("buserr_pulse", vi, 0, 32'(bus_err_o), 32'd0);
            check("dout_after", vi, 0, cpu_dout_o, cur_dout);
        end
    endtask

    initial begin
        int ar0;
        rst = 0;
        cpu_request_i = 0; cpu_bweb_i = 4'hF; cpu_addr_i = 0; cpu_din_i = 0;
        idle_slave();
        repeat (3) @(negedge clk);
        #1;
        check_all_idle("reset", -1);
        check("reset_wait", -1, 0, 32'(cpu_wait_o), 32'd0);
        check("reset_wdata", -1, 0, WDATA, 32'd0);
        check("reset_wstrb", -1, 0, 32'(WSTRB), 32'd0);
        @(negedge clk);
        rst = 1;

        //  bweb   addr          din           rdata         resp bid rl ar aw w rsp hold drop strb   dout          err
        add(4'hF, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 4'h0, 32'hDEADBEEF, 0);
        add(4'hE, 32'h0000_0204, 32'h12345678, 32'h0,        2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 4'h1, 32'hDEADBEEF, 0);
        add(4'h0, 32'h0000_0300, 32'hA5A55A5A, 32'h0,        2'b00, 0, 1, 0, 0, 3, 0, 0, 0, 4'hF, 32'hDEADBEEF, 0);
        add(4'h3, 32'h0000_0308, 32'h0F0F0F0F, 32'h0,        2'b00, 0, 1, 0, 2, 0, 1, 0, 0, 4'hC, 32'hDEADBEEF, 0);
        add(4'hF, 32'h0000_040C, 32'h0,        32'hCAFEF00D, 2'b00, 0, 1, 2, 0, 0, 1, 0, 0, 4'h0, 32'hCAFEF00D, 0);
        add(4'hF, 32'h0000_0500, 32'h0,        32'h11112222, 2'b10, 0, 1, 0, 0, 0, 0, 0, 0, 4'h0, 32'h11112222, 1);
        add(4'hF, 32'h0000_0504, 32'h0,        32'h33334444, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 4'h0, 32'h33334444, 1);
        add(4'hF, 32'h0000_0508, 32'h0,        32'h55556666, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 32'h55556666, 1);
        add(4'h5, 32'h0000_0600, 32'h00000009, 32'h0,        2'b11, 0, 1, 0, 0, 0, 0, 0, 0, 4'hA, 32'h55556666, 1);
        add(4'h0, 32'h0000_0604, 32'hFFFF0000, 32'h0,        2'b00, 1, 1, 0, 1, 0, 0, 0, 0, 4'hF, 32'h55556666, 1);
        add(4'hF, 32'h0000_0700, 32'h0,        32'h77778888, 2'b00, 0, 1, 1, 0, 0, 1, 0, 1, 4'h0, 32'h77778888, 0);
        add(4'hF, 32'h0000_0000, 32'h0,        32'hA0000000, 2'b00, 0, 1, 0, 0, 0, 0, 1, 0, 4'h0, 32'hA0000000, 0);
        add(4'hF, 32'h0000_0004, 32'h0,        32'hA0000004, 2'b00, 0, 1, 0, 0, 0, 0, 1, 0, 4'h0, 32'hA0000004, 0);
        add(4'hF, 32'h0000_0008, 32'h0,        32'hA0000008, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 4'h0, 32'hA0000008, 0);
        add(4'hC, 32'h0000_0800, 32'h88889999, 32'h0,        2'b00, 0, 1, 0, 1, 1, 2, 0, 0, 4'h3, 32'hA0000008, 0);
        add(4'hF, 32'h0000_0900, 32'h0,        32'h0BADCAFE, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 4'h0, 32'h0BADCAFE, 0);

        for (int i = 0; i <= 10; i++) do_txn(i);

        ar0 = ar_hs_cnt;
        for (int i = 11; i <= 13; i++) do_txn(i);
        check("b2b_ar_count", 13, 0, 32'(ar_hs_cnt - ar0), 32'd3);

        do_txn(14);

        // Reset while waiting for read data: everything must go quiet at once.
        @(negedge clk);
        cpu_request_i = 1; cpu_bweb_i = 4'hF; cpu_addr_i = 32'h0000_0400;
        idle_slave();
        @(negedge clk);
        ARREADY = 1;
        #1;
        check("rst_seq_arvalid", 16, 1, 32'(ARVALID), 32'd1);
        @(negedge clk);
        ARREADY = 0; RVALID = 0;
        #1;
        check("rst_seq_rready", 16, 2, 32'(RREADY), 32'd1);
        rst = 0;
        @(negedge clk);
        cpu_request_i = 0;
        #1;
        check_all_idle("midrst", 16);
        cur_dout = 32'h0;
        rst = 1;
        @(negedge clk);
        RVALID = 1; RDATA = 32'hFEEDFACE;
        #1;
        check("midrst_rready", 16, 4, 32'(RREADY), 32'd0);
        check("midrst_arvalid", 16, 4, 32'(ARVALID), 32'd0);
        @(negedge clk);
        idle_slave();
        #1;
        check("midrst_dout", 16, 5, cpu_dout_o, 32'd0);

        do_txn(15);

        check("sb_drained", -1, 0, 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
